// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode,
// with a single-cycle flush for redirects and a compressed-encoding flag on the head entry.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  output logic                       fetch_ready,
  input  logic [31:0]                fetch_pc,
  input  logic [31:0]                fetch_instr,
  input  logic                       flush,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_pc,
  output logic [31:0]                dec_instr,
  output logic                       dec_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          enq, deq;

  function automatic logic is_compressed(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

  // Handshakes depend only on registered count, so no fetch->dec or dec_ready->fetch_ready path.
  assign fetch_ready = (count_q != CW'(DEPTH));
  assign dec_valid   = (count_q != '0);
  assign enq         = fetch_valid && fetch_ready && !flush;
  assign deq         = dec_valid && dec_ready && !flush;

  assign dec_pc      = pc_mem_q[rd_ptr_q];
  assign dec_instr   = instr_mem_q[rd_ptr_q];
  assign dec_illegal = is_compressed(instr_mem_q[rd_ptr_q]);
  assign count       = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity comes solely from count and the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc;
      instr_mem_q[wr_ptr_q] <= fetch_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, all checked against a
// queue-based reference model of the FIFO behaviour.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_instr;
  logic          flush;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic          dec_illegal;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] mdl[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_illegal (dec_illegal),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] head;
    chk({tag, "_count"}, 32'(count), 32'(mdl.size()));
    chk({tag, "_fready"}, 32'(fetch_ready), 32'(mdl.size() != DEPTH));
    chk({tag, "_dvalid"}, 32'(dec_valid), 32'(mdl.size() != 0));
    if (mdl.size() != 0) begin
      head = mdl[0];
      chk({tag, "_pc"}, dec_pc, head[63:32]);
      chk({tag, "_instr"}, dec_instr, head[31:0]);
      chk({tag, "_illegal"}, 32'(dec_illegal), 32'(head[1:0] != 2'b11));
    end
  endtask

  // Drive one cycle, check pre-edge outputs against the model, then advance model and clock.
  task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic dr, input logic fl);
    logic ex_enq, ex_deq;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    dec_ready   = dr;
    flush       = fl;
    #1;
    check_model(tag);
    ex_enq = fv && (mdl.size() != DEPTH) && !fl;
    ex_deq = dr && (mdl.size() != 0) && !fl;
    @(posedge clk);
    if (fl) mdl.delete();
    else begin
      if (ex_deq) void'(mdl.pop_front());
      if (ex_enq) mdl.push_back({pc, ins});
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
    flush = 1'b0; dec_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dvalid", 32'(dec_valid), 32'd0);
    chk("rst_fready", 32'(fetch_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check_model("post_rst");

    // Single enqueue, visible the next cycle
    step("s1", 1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
    fetch_valid = 1'b0; #1;
    chk("s1_dvalid", 32'(dec_valid), 32'd1);
    chk("s1_pc", dec_pc, 32'h0);
    chk("s1_instr", dec_instr, 32'h00000013);
    chk("s1_count", 32'(count), 32'd1);

    // Fill past full, then drain in order
    step("fl0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, 32'(i * 4), 32'h00100093 + 32'(i << 7), 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_fready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b0; #1;
      chk("drain_pc", dec_pc, 32'(i * 4));
      step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(dec_valid), 32'd0);

    // Streaming with pointer wrap
    for (int i = 0; i < 12; i++) begin
      step("stream", 1'b1, 32'h1000 + 32'(i * 4), 32'h00000013 + 32'(i << 20), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd1);
    end
    step("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent enqueue
    for (int i = 0; i < 3; i++)
      step("pre_flush", 1'b1, 32'h2000 + 32'(i * 4), 32'h00000033, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd3);
    step("flush", 1'b1, 32'h3000, 32'h00000073, 1'b1, 1'b1);
    fetch_valid = 1'b0; flush = 1'b0; #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_dvalid", 32'(dec_valid), 32'd0);
    chk("flush_fready", 32'(fetch_ready), 32'd1);

    // Compressed-encoding flag
    step("ill_a", 1'b1, 32'h40, 32'h00004501, 1'b0, 1'b0);
    step("ill_b", 1'b1, 32'h42, 32'h00000013, 1'b0, 1'b0);
    chk("ill_set", 32'(dec_illegal), 32'd1);
    step("ill_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ill_clr", 32'(dec_illegal), 32'd0);
    step("ill_pop2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    step("ar_a", 1'b1, 32'h500, 32'h00000013, 1'b0, 1'b0);
    step("ar_b", 1'b1, 32'h504, 32'h00000093, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd2);
    #2; rst_n = 1'b0; #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_dvalid", 32'(dec_valid), 32'd0);
    chk("ar_fready", 32'(fetch_ready), 32'd1);
    mdl.delete();
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    step("ar_first", 1'b1, 32'h600, 32'h00000113, 1'b0, 1'b0);
    fetch_valid = 1'b0; #1;
    chk("ar_first_pc", dec_pc, 32'h600);

    // Randomized traffic with varying bias
    for (int i = 0; i < 600; i++) begin
      logic fv, dr, fl;
      int   bias;
      bias = (i / 100) % 3;
      fv = (bias == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      dr = (bias == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 29) == 0);
      step("rand", fv, $urandom, $urandom, dr, fl);
    end
    check_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port fetch_valid, input, 1 bit: the fetch stage presents an instruction.
REQ-005 The block SHALL have port fetch_ready, output, 1 bit: the queue accepts an instruction this cycle.
REQ-006 The block SHALL have port fetch_pc, input, 32 bits: PC of the presented instruction.
REQ-007 The block SHALL have port fetch_instr, input, 32 bits: the presented instruction word.
REQ-008 The block SHALL have port flush, input, 1 bit: discard all held entries (branch/jump redirect).
REQ-009 The block SHALL have port dec_valid, output, 1 bit: the head entry is valid for decode.
REQ-010 The block SHALL have port dec_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-011 The block SHALL have port dec_pc, output, 32 bits: PC of the head entry.
REQ-012 The block SHALL have port dec_instr, output, 32 bits: instruction of the head entry.
REQ-013 The block SHALL have port dec_illegal, output, 1 bit: head instruction has instr[1:0] != 2'b11 (compressed encoding, unsupported).
REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of valid entries.

Function
REQ-015 Enqueue SHALL occur on a rising edge when fetch_valid && fetch_ready && !flush.
REQ-016 Dequeue SHALL occur on a rising edge when dec_valid && dec_ready && !flush.
REQ-017 fetch_ready SHALL equal (count != DEPTH); there is no full-queue bypass.
REQ-018 dec_valid SHALL equal (count != 0); there is no empty-queue bypass, so an enqueued entry first appears on dec_* the cycle after its enqueue edge (latency 1).
REQ-019 dec_pc, dec_instr and dec_illegal SHALL be driven combinationally from the head entry; when dec_valid is 0 their values are don't-care.
REQ-020 Entries SHALL leave in strict enqueue order, with pc and instr kept paired.
REQ-021 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
REQ-023 count SHALL increment by 1 on enqueue-only, decrement by 1 on dequeue-only, and never exceed DEPTH or go below 0.
REQ-024 On a flush edge, count and both pointers SHALL go to 0 regardless of fetch_valid/dec_ready; any same-cycle enqueue or dequeue is suppressed.
REQ-025 After a flush edge, dec_valid SHALL be 0 and fetch_ready SHALL be 1 in the following cycle.
REQ-026 Entry storage SHALL need no reset; validity is determined only by count and the pointers.
REQ-027 The outputs SHALL have no combinational path from fetch_* to dec_* or from dec_ready to fetch_ready.

Reset
REQ-028 While rst_n = 0, count, read pointer and write pointer SHALL be 0 immediately, independent of clk.
REQ-029 During and after reset, outputs SHALL be dec_valid = 0, fetch_ready = 1, count = 0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first entry seen after release SHALL be the first one enqueued after release.

Verification
REQ-031 Reset, then enqueue pc=0x0 instr=0x00000013 with dec_ready=0 -> the next cycle dec_valid=1, dec_pc=0x0, dec_instr=0x00000013, count=1.
REQ-032 DEPTH=4: enqueue 5 times with dec_ready=0 -> count=4 and fetch_ready=0 after the 4th edge; the 5th is not accepted; dequeue gives pc 0x0,0x4,0x8,0xC in order.
REQ-033 Continuous streaming with fetch_valid=1 and dec_ready=1 for 12 cycles with pc stepping +4 -> count stays 1 after the first cycle, every pc appears exactly once in order, and the pointers wrap.
REQ-034 With count=3, flush=1 together with fetch_valid=1 -> the next cycle count=0, dec_valid=0, and the flushing-cycle instruction is not stored.
REQ-035 Enqueue instr=0x00004501 -> at the head, dec_illegal=1; instr=0x00000013 -> dec_illegal=0.
REQ-036 Assert rst_n=0 between clock edges while count=2 -> count=0 and dec_valid=0 before the next rising edge.
